// File: rtl/mprj_io_serial_loader.sv
// ============================================================================
// Module  : mprj_io_serial_loader
// Purpose : Shifts per-pad configuration words into the GPIO control chain
//           and commits them with a single load strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mprj_io_serial_loader #(
    parameter int NPADS    = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 4,
    parameter int ADDR_W   = $clog2(NPADS)
) (
    input  logic                clock,
    input  logic                resetb,
    input  logic                start,
    input  logic                abort,
    output logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                serial_resetn
);

    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;

    localparam logic [DIV_W-1:0]  c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  c_BIT_LAST = BIT_W'(CFG_BITS - 1);
    localparam logic [ADDR_W-1:0] c_PAD_LAST = ADDR_W'(NPADS - 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_FETCH    = 3'd1;
    localparam logic [2:0] c_SHIFT_LO = 3'd2;
    localparam logic [2:0] c_SHIFT_HI = 3'd3;
    localparam logic [2:0] c_LOAD     = 3'd4;
    localparam logic [2:0] c_DONE     = 3'd5;

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_pad;
    logic [BIT_W-1:0]    r_bit;
    logic [DIV_W-1:0]    r_div;
    logic [CFG_BITS-1:0] r_shreg;
    logic [1:0]          r_rst_sync;
    logic                r_busy;
    logic                r_done;
    logic                r_sclk;
    logic                r_sdata;
    logic                r_sload;
    logic                w_div_end;

    assign w_div_end = (r_div == '0);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= c_IDLE;
            r_pad   <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_shreg <= '0;
        end else if (abort && (r_state != c_IDLE)) begin
            // Chain keeps whatever was shifted so far; it is simply never loaded.
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_pad   <= c_PAD_LAST;
                        r_state <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    r_shreg <= cfg_data;
                    r_bit   <= c_BIT_LAST;
                    r_div   <= c_DIV_LAST;
                    r_state <= c_SHIFT_LO;
                end
                c_SHIFT_LO: begin
                    if (w_div_end) begin
                        r_div   <= c_DIV_LAST;
                        r_state <= c_SHIFT_HI;
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                c_SHIFT_HI: begin
                    if (w_div_end) begin
                        r_shreg <= {r_shreg[CFG_BITS-2:0], 1'b0};
                        r_div   <= c_DIV_LAST;
                        if (r_bit != '0) begin
                            r_bit   <= r_bit - BIT_W'(1);
                            r_state <= c_SHIFT_LO;
                        end else if (r_pad != '0) begin
                            r_pad   <= r_pad - ADDR_W'(1);
                            r_state <= c_FETCH;
                        end else begin
                            r_state <= c_LOAD;
                        end
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                c_LOAD: begin
                    if (w_div_end) begin
                        r_state <= c_DONE;
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Outputs are registered decodes of the state, so they trail it by one cycle.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sdata <= 1'b0;
            r_sload <= 1'b0;
        end else begin
            r_busy  <= (r_state == c_FETCH) || (r_state == c_SHIFT_LO) ||
                       (r_state == c_SHIFT_HI) || (r_state == c_LOAD);
            r_done  <= (r_state == c_DONE);
            r_sclk  <= (r_state == c_SHIFT_HI);
            r_sload <= (r_state == c_LOAD);
            if (r_state == c_SHIFT_LO) begin
                r_sdata <= r_shreg[CFG_BITS-1];
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign cfg_addr      = r_pad;
    assign busy          = r_busy;
    assign done          = r_done;
    assign serial_clock  = r_sclk;
    assign serial_data   = r_sdata;
    assign serial_load   = r_sload;
    assign serial_resetn = r_rst_sync[1];

endmodule

`default_nettype wire
